// File: rtl/aes_pkg.sv
// Shared AES-128 types, rcon table and forward round primitives (SubBytes, ShiftRows, MixColumns, AddRoundKey).
// Byte 0 of a block sits in bits [127:120]; the state is column-major (byte i -> row i%4, column i/4).
package aes_pkg;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] LAST_RND = 4'd10;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Round constants for rounds 1..10; other indices never occur in RUN.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [2047:0] t;
    t = SBOX_TBL << {x, 3'b000};
    return t[2047:2040];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic block_t sub_bytes(input block_t s);
    block_t r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
    return r;
  endfunction

  function automatic block_t shift_rows(input block_t s);
    block_t r;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic block_t mix_columns(input block_t s);
    block_t r;
    logic [31:0] col;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      col = s[127-32*c -: 32];
      {a0, a1, a2, a3} = col;
      r[127-32*c -: 32] = {
        xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
        xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
      };
    end
    return r;
  endfunction

  function automatic block_t add_round_key(input block_t s, input block_t rk);
    return s ^ rk;
  endfunction

endpackage

// File: rtl/aes_enc_iter_key_expand_step.sv
// One AES-128 key-schedule step: previous round key plus rcon -> next round key.
// Purely combinational; no handshake.
module key_expand_step
  import aes_pkg::*;
(
  input  logic [127:0] prev_key,
  input  logic [7:0]   rc,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3, temp, n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = prev_key;
  assign temp = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryptor, one round per cycle with on-the-fly key expansion; AES_ENC_LAST_KEY_OUT_EN adds last_key.
// Latency: job accepted at edge T, out_valid high after edge T+10; back-to-back jobs every 11 cycles.
// Backpressure: ciphertext held in DONE until out_ready; in_ready only in IDLE or on the DONE handoff.
module aes_enc_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext
`ifdef AES_ENC_LAST_KEY_OUT_EN
  ,
  output logic [127:0] last_key
`endif
);

  state_e     state, state_nxt;
  block_t     state_reg, rk_reg, rk_next, sr, round_out;
  logic [3:0] rnd;
  logic       accept, last_rnd;

  assign accept   = in_valid & in_ready;
  assign last_rnd = (rnd == LAST_RND);

  key_expand_step u_key_expand (
    .prev_key (rk_reg),
    .rc       (rcon(rnd)),
    .next_key (rk_next)
  );

  // The final round skips MixColumns.
  assign sr        = shift_rows(sub_bytes(state_reg));
  assign round_out = add_round_key(last_rnd ? sr : mix_columns(sr), rk_next);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last_rnd) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = in_valid ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rnd        <= 4'd0;
      out_valid  <= 1'b0;
      ciphertext <= '0;
      state_reg  <= '0;
      rk_reg     <= '0;
`ifdef AES_ENC_LAST_KEY_OUT_EN
      last_key   <= '0;
`endif
    end else begin
      if ((state == DONE) && out_ready) out_valid <= 1'b0;
      if (accept) begin
        state_reg <= plaintext ^ key;
        rk_reg    <= key;
        rnd       <= 4'd1;
      end else if (state == RUN) begin
        state_reg <= round_out;
        rk_reg    <= rk_next;
        if (last_rnd) begin
          ciphertext <= round_out;
          out_valid  <= 1'b1;
`ifdef AES_ENC_LAST_KEY_OUT_EN
          last_key   <= rk_next;
`endif
        end else begin
          rnd <= rnd + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_enc_iter.sv
// Self-checking bench for aes_enc_iter: known-answer vectors, latency, backpressure, handoff and mid-run reset.
// Expected ciphertexts are queued when a job is driven and popped when out_valid rises.
module tb_aes_enc_iter;

  typedef struct {
    logic [127:0] ct;
    logic [127:0] lk;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
`ifdef AES_ENC_LAST_KEY_OUT_EN
  logic [127:0] last_key;
`endif

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] LK1 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] LK2 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] CT3 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] LK3 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_enc_iter dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext)
`ifdef AES_ENC_LAST_KEY_OUT_EN
    ,
    .last_key   (last_key)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required summary before timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one job for one edge (caller has confirmed in_ready) and queues its expected result.
  task automatic drive_job(input logic [127:0] pt, input logic [127:0] k,
                           input logic [127:0] ct, input logic [127:0] lk);
    exp_t e;
    in_valid  = 1'b1;
    plaintext = pt;
    key       = k;
    e.ct = ct;
    e.lk = lk;
    exp_q.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  // Cycles until out_valid is seen, or -1 if it never rises within the bound.
  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (out_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pop_exp(output exp_t e);
    if (exp_q.size() == 0) begin
      e.ct = 'x;
      e.lk = 'x;
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; plaintext = '0; key = '0;
    tick(); tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (ciphertext !== '0) begin bad++; $display("FAIL reset_ct: got %h want 0", ciphertext); end
`ifdef AES_ENC_LAST_KEY_OUT_EN
    total++; if (last_key !== '0) begin bad++; $display("FAIL reset_last_key: got %h want 0", last_key); end
`endif
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_vectors();
    logic [127:0] pts [3] = '{PT1, PT2, 128'h0};
    logic [127:0] ks  [3] = '{K1, K2, 128'h0};
    logic [127:0] cts [3] = '{CT1, CT2, CT3};
    logic [127:0] lks [3] = '{LK1, LK2, LK3};
    exp_t e;
    int n;
    out_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      drive_job(pts[v], ks[v], cts[v], lks[v]);
      wait_valid(n);
      total++; if (n !== 10) begin bad++; $display("FAIL vec%0d_latency: got %0d want 10", v, n); end
      pop_exp(e);
      total++; if (ciphertext !== e.ct) begin bad++; $display("FAIL vec%0d_ct: got %h want %h", v, ciphertext, e.ct); end
`ifdef AES_ENC_LAST_KEY_OUT_EN
      total++; if (last_key !== e.lk) begin bad++; $display("FAIL vec%0d_last_key: got %h want %h", v, last_key, e.lk); end
`endif
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL vec%0d_handoff: out_valid got %b want 0", v, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int n;
    int held_bad = 0;
    out_ready = 1'b0;
    drive_job(PT2, K2, CT2, LK2);
    wait_valid(n);
    total++; if (n !== 10) begin bad++; $display("FAIL bp_latency: got %0d want 10", n); end
    pop_exp(e);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; plaintext = PT1; key = K1;
      #1;
      if (in_ready !== 1'b0) held_bad++;
      tick();
      if (out_valid !== 1'b1 || ciphertext !== e.ct) held_bad++;
    end
    total++; if (held_bad !== 0) begin bad++; $display("FAIL bp_hold: %0d bad cycles, want 0 (ct %h want %h)", held_bad, ciphertext, e.ct); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release: out_valid got %b want 0", out_valid); end
    wait_valid(n);
    total++; if (n !== -1) begin bad++; $display("FAIL bp_ignored_job: out_valid after %0d cycles, want none", n); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n;
    out_ready = 1'b1;
    drive_job(PT1, K1, CT1, LK1);
    in_valid = 1'b1; plaintext = PT2; key = K2;
    wait_valid(n);
    total++; if (n !== 10) begin bad++; $display("FAIL b2b_first_latency: got %0d want 10", n); end
    pop_exp(e);
    total++; if (ciphertext !== e.ct) begin bad++; $display("FAIL b2b_first_ct: got %h want %h", ciphertext, e.ct); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
    drive_job(PT2, K2, CT2, LK2);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_handoff: out_valid got %b want 0", out_valid); end
    wait_valid(n);
    total++; if (n + 1 !== 11) begin bad++; $display("FAIL b2b_spacing: got %0d want 11", n + 1); end
    pop_exp(e);
    total++; if (ciphertext !== e.ct) begin bad++; $display("FAIL b2b_second_ct: got %h want %h", ciphertext, e.ct); end
`ifdef AES_ENC_LAST_KEY_OUT_EN
    total++; if (last_key !== e.lk) begin bad++; $display("FAIL b2b_second_last_key: got %h want %h", last_key, e.lk); end
`endif
    tick();
  endtask

  task automatic test_reset_midrun();
    exp_t e;
    int n;
    out_ready = 1'b1;
    drive_job(PT1, K1, CT1, LK1);
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pop_exp(e);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
    total++; if (ciphertext !== '0) begin bad++; $display("FAIL rst_mid_ct: got %h want 0", ciphertext); end
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_idle: in_ready got %b want 1", in_ready); end
    wait_valid(n);
    total++; if (n !== -1) begin bad++; $display("FAIL rst_mid_no_pulse: out_valid after %0d cycles, want none", n); end
    drive_job(PT2, K2, CT2, LK2);
    wait_valid(n);
    total++; if (n !== 10) begin bad++; $display("FAIL rst_fresh_latency: got %0d want 10", n); end
    pop_exp(e);
    total++; if (ciphertext !== e.ct) begin bad++; $display("FAIL rst_fresh_ct: got %h want %h", ciphertext, e.ct); end
    tick();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_back_to_back();
    test_reset_midrun();
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
